// File: rtl/wdg_pkg.sv
// Shared types and watchdog register map for the watchdog Wishbone initiator
// and anything else that talks to the watchdog register file.
package wdg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        GAP,
        RESP
    } wb_state_e;

    localparam logic [1:0] WDCSR_ADR = 2'd0;
    localparam logic [1:0] WDCNT_ADR = 2'd1;

    // WDCSR field positions
    localparam int WDCSR_WDEN_BIT   = 0;
    localparam int WDCSR_S1WTO_BIT  = 2;
    localparam int WDCSR_S2WTO_BIT  = 3;
    localparam int WDCSR_WTOCNT_LSB = 4;
    localparam int WDCSR_WTOCNT_MSB = 13;

endpackage

// File: rtl/wdg_wb_timeout.sv
// Loadable saturating up-counter with synchronous clear and an equal-to-limit
// flag; used to bound how long the initiator waits for a slave response.
module wdg_wb_timeout
    import wdg_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_eq
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_eq = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/wdg_wb_initiator.sv
// Single-outstanding Wishbone pipelined initiator: one bus transaction per
// command, with stall handling, bounded retry on rty and a response timeout.
module wdg_wb_initiator
    import wdg_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3,
    localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_adr,
    input  logic [DATA_WIDTH-1:0]    i_cmd_dat,
    input  logic [SEL_WIDTH-1:0]     i_cmd_sel,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_dat,
    output logic                     o_rsp_err,
    output logic                     o_rsp_timeout,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
    output logic [DATA_WIDTH-1:0]    o_wb_dat,
    output logic [SEL_WIDTH-1:0]     o_wb_sel,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_err,
    input  logic                     i_wb_rty,
    input  logic [DATA_WIDTH-1:0]    i_wb_dat
);

    wb_state_e state_q, state_d;

    logic                     cmd_we_q,  cmd_we_d;
    logic [ADDRESS_WIDTH-1:0] cmd_adr_q, cmd_adr_d;
    logic [DATA_WIDTH-1:0]    cmd_dat_q, cmd_dat_d;
    logic [SEL_WIDTH-1:0]     cmd_sel_q, cmd_sel_d;
    logic [3:0]               retry_q,   retry_d;
    logic [DATA_WIDTH-1:0]    rsp_dat_q, rsp_dat_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     rsp_to_q,  rsp_to_d;

    logic                     cyc_d, stb_d, we_d, rsp_valid_d;
    logic [ADDRESS_WIDTH-1:0] adr_d;
    logic [DATA_WIDTH-1:0]    wdat_d;
    logic [SEL_WIDTH-1:0]     sel_d;
    logic                     to_eq;

    // Counter restarts on every (re)issue so each attempt gets the full budget
    wdg_wb_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .res_n     (res_n),
        .i_clr     ((state_d == REQ) && (state_q != REQ)),
        .i_load    (1'b0),
        .i_load_val('0),
        .i_inc     (state_q == WAIT),
        .o_eq      (to_eq)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Latched command carries data only; state decides when it is visible
    always_ff @(posedge clk) begin
        cmd_we_q  <= cmd_we_d;
        cmd_adr_q <= cmd_adr_d;
        cmd_dat_q <= cmd_dat_d;
        cmd_sel_q <= cmd_sel_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_we_d  = cmd_we_q;
        cmd_adr_d = cmd_adr_q;
        cmd_dat_d = cmd_dat_q;
        cmd_sel_d = cmd_sel_q;
        retry_d   = retry_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_to_d  = rsp_to_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    cmd_we_d  = i_cmd_we;
                    cmd_adr_d = i_cmd_adr;
                    cmd_dat_d = i_cmd_dat;
                    cmd_sel_d = i_cmd_sel;
                    retry_d   = '0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    rsp_to_d  = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (!i_wb_stall) state_d = WAIT;
            end
            WAIT: begin
                // err > rty > ack > timeout
                if (i_wb_err) begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else if (i_wb_rty) begin
                    if (retry_q < 4'(MAX_RETRY)) begin
                        retry_d = retry_q + 4'd1;
                        state_d = GAP;
                    end else begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end
                end else if (i_wb_ack) begin
                    if (!cmd_we_q) rsp_dat_d = i_wb_dat;
                    state_d = RESP;
                end else if (to_eq) begin
                    rsp_err_d = 1'b1;
                    rsp_to_d  = 1'b1;
                    state_d   = RESP;
                end
            end
            GAP:  state_d = REQ;
            RESP: begin
                if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = (state_d == REQ) || (state_d == WAIT);
        stb_d       = (state_d == REQ);
        we_d        = cyc_d ? cmd_we_d  : 1'b0;
        adr_d       = cyc_d ? cmd_adr_d : '0;
        sel_d       = cyc_d ? cmd_sel_d : '0;
        wdat_d      = (cyc_d && cmd_we_d) ? cmd_dat_d : '0;
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_sel    <= '0;
            o_wb_dat    <= '0;
            o_rsp_valid <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            o_wb_cyc    <= cyc_d;
            o_wb_stb    <= stb_d;
            o_wb_we     <= we_d;
            o_wb_adr    <= adr_d;
            o_wb_sel    <= sel_d;
            o_wb_dat    <= wdat_d;
            o_rsp_valid <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_rsp_dat     = rsp_dat_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_to_q;

endmodule
